// File: rtl/spi_master_fl_mq.sv
// rtl/spi_master_fl_mq.sv - SPI flash frame engine: cmd/addr/dummy/data phases with per-phase lane width
module spi_master_fl_mq #(
    parameter int DATA_W  = 32,
    parameter int NBITS_W = 7,
    parameter int DUMMY_W = 4,
    parameter int DIV_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid,
    output logic               ready,
    input  logic [7:0]         command,
    input  logic [31:0]        address,
    input  logic               addr_en,
    input  logic               fourbyte,
    input  logic [DUMMY_W-1:0] dummy_cycles,
    input  logic [NBITS_W-1:0] ndata_bits,
    input  logic               dir,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [1:0]         cmd_lanes,
    input  logic [1:0]         addr_lanes,
    input  logic [1:0]         data_lanes,
    input  logic [DIV_W-1:0]   clk_div,
    input  logic               cpol,
    output logic [DATA_W-1:0]  data_out,
    output logic               done,
    output logic               sclk,
    output logic               ss,
    output logic [3:0]         dq_out,
    output logic [3:0]         dq_oe,
    input  logic [3:0]         dq_in
);
    localparam int SLOT_W = ((NBITS_W > 6) ? NBITS_W : 6) + 1;
    localparam int RX_W   = DATA_W + 4;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END, S_GAP
    } state_t;

    state_t              state_q, state_d, next_phase;
    logic [DIV_W-1:0]    div_q, div_d, div_cnt_q, div_cnt_d;
    logic                half_q, half_d;
    logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d, phase_slots;
    logic [7:0]          cmd_sh_q, cmd_sh_d;
    logic [31:0]         addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [RX_W-1:0]     rx_q, rx_d, rx_shift;
    logic                addr_en_q, addr_en_d, fourbyte_q, fourbyte_d;
    logic                dir_q, dir_d, cpol_q, cpol_d;
    logic [DUMMY_W-1:0]  dummy_q, dummy_d;
    logic [NBITS_W-1:0]  nbits_q, nbits_d, nbits_in;
    logic [SLOT_W-1:0]   data_slots_q, data_slots_d, data_slots_in;
    logic [1:0]          cmd_lg_q, cmd_lg_d, addr_lg_q, addr_lg_d, data_lg_q, data_lg_d, lg_in;
    logic [DATA_W-1:0]   data_out_q, data_out_d, tx_in;
    logic [SLOT_W+1:0]   ceil_sum, rx_bits, surplus;
    logic                last_half, in_slot;

    // Lane code to log2(lane count); code 3 falls back to single lane.
    function automatic logic [1:0] lane_lg(input logic [1:0] code);
        case (code)
            2'd1:    return 2'd1;
            2'd2:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // Returns {oe, out}; the highest active lane carries the MSB, WP#/HOLD# held high when unused.
    function automatic logic [7:0] drive_lanes(input logic [3:0] top, input logic [1:0] lg);
        case (lg)
            2'd1:    return {4'b1111, 2'b11, top[3:2]};
            2'd2:    return {4'b1111, top};
            default: return {4'b1101, 2'b11, 1'b0, top[3]};
        endcase
    endfunction

    always_comb begin
        nbits_in      = (int'(ndata_bits) > DATA_W) ? NBITS_W'(DATA_W) : ndata_bits;
        lg_in         = lane_lg(data_lanes);
        ceil_sum      = (SLOT_W+2)'(nbits_in) + ((SLOT_W+2)'(1) << lg_in) - (SLOT_W+2)'(1);
        data_slots_in = SLOT_W'(ceil_sum >> lg_in);
        tx_in         = data_in << (DATA_W - int'(nbits_in));
        rx_bits       = (SLOT_W+2)'(data_slots_q) << data_lg_q;
        surplus       = rx_bits - (SLOT_W+2)'(nbits_q);
        case (data_lg_q)
            2'd1:    rx_shift = {rx_q[RX_W-3:0], dq_in[1:0]};
            2'd2:    rx_shift = {rx_q[RX_W-5:0], dq_in};
            default: rx_shift = {rx_q[RX_W-2:0], dq_in[1]};
        endcase
    end

    always_comb begin
        case (state_q)
            S_CMD:   next_phase = addr_en_q ? S_ADDR :
                                  (dummy_q != '0) ? S_DUMMY :
                                  (nbits_q != '0) ? S_DATA : S_END;
            S_ADDR:  next_phase = (dummy_q != '0) ? S_DUMMY :
                                  (nbits_q != '0) ? S_DATA : S_END;
            S_DUMMY: next_phase = (nbits_q != '0) ? S_DATA : S_END;
            default: next_phase = S_END;
        endcase
        case (next_phase)
            S_ADDR:  phase_slots = SLOT_W'((fourbyte_q ? 6'd32 : 6'd24) >> addr_lg_q);
            S_DUMMY: phase_slots = SLOT_W'(dummy_q);
            S_DATA:  phase_slots = data_slots_q;
            default: phase_slots = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        div_cnt_d    = div_cnt_q;
        half_d       = half_q;
        slot_cnt_d   = slot_cnt_q;
        cmd_sh_d     = cmd_sh_q;
        addr_sh_d    = addr_sh_q;
        tx_sh_d      = tx_sh_q;
        rx_d         = rx_q;
        addr_en_d    = addr_en_q;
        fourbyte_d   = fourbyte_q;
        dir_d        = dir_q;
        cpol_d       = cpol_q;
        dummy_d      = dummy_q;
        nbits_d      = nbits_q;
        data_slots_d = data_slots_q;
        cmd_lg_d     = cmd_lg_q;
        addr_lg_d    = addr_lg_q;
        data_lg_d    = data_lg_q;
        data_out_d   = data_out_q;
        last_half    = (div_cnt_q == div_q);
        case (state_q)
            S_IDLE: begin
                cpol_d = cpol;
                if (valid) begin
                    state_d      = S_CMD;
                    div_d        = clk_div;
                    div_cnt_d    = '0;
                    half_d       = 1'b0;
                    slot_cnt_d   = SLOT_W'(4'd8 >> lane_lg(cmd_lanes));
                    cmd_sh_d     = command;
                    addr_sh_d    = fourbyte ? address : {address[23:0], 8'h00};
                    tx_sh_d      = tx_in;
                    rx_d         = '0;
                    addr_en_d    = addr_en;
                    fourbyte_d   = fourbyte;
                    dir_d        = dir;
                    dummy_d      = dummy_cycles;
                    nbits_d      = nbits_in;
                    data_slots_d = data_slots_in;
                    cmd_lg_d     = lane_lg(cmd_lanes);
                    addr_lg_d    = lane_lg(addr_lanes);
                    data_lg_d    = lg_in;
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                div_cnt_d = div_cnt_q + 1'b1;
                if (last_half) begin
                    div_cnt_d = '0;
                    half_d    = ~half_q;
                    if (!half_q) begin
                        if (state_q == S_DATA && !dir_q)
                            rx_d = rx_shift;
                    end else begin
                        case (state_q)
                            S_CMD:   cmd_sh_d  = cmd_sh_q << (3'd1 << cmd_lg_q);
                            S_ADDR:  addr_sh_d = addr_sh_q << (3'd1 << addr_lg_q);
                            S_DATA:  tx_sh_d   = tx_sh_q << (3'd1 << data_lg_q);
                            default: ;
                        endcase
                        if (slot_cnt_q == SLOT_W'(1)) begin
                            state_d    = next_phase;
                            slot_cnt_d = phase_slots;
                        end else begin
                            slot_cnt_d = slot_cnt_q - 1'b1;
                        end
                    end
                end
            end
            S_END: begin
                div_cnt_d = div_cnt_q + 1'b1;
                if (last_half) begin
                    state_d   = S_GAP;
                    div_cnt_d = '0;
                    // Surplus bits of a rounded-up final slot arrive last, so shifting them off leaves the frame's bits.
                    if (!dir_q)
                        data_out_d = DATA_W'(rx_q >> surplus);
                end
            end
            S_GAP: begin
                div_cnt_d = div_cnt_q + 1'b1;
                if (last_half) begin
                    state_d   = S_IDLE;
                    div_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            div_cnt_q    <= '0;
            half_q       <= 1'b0;
            slot_cnt_q   <= '0;
            cmd_sh_q     <= '0;
            addr_sh_q    <= '0;
            tx_sh_q      <= '0;
            rx_q         <= '0;
            addr_en_q    <= 1'b0;
            fourbyte_q   <= 1'b0;
            dir_q        <= 1'b0;
            cpol_q       <= 1'b0;
            dummy_q      <= '0;
            nbits_q      <= '0;
            data_slots_q <= '0;
            cmd_lg_q     <= '0;
            addr_lg_q    <= '0;
            data_lg_q    <= '0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            div_cnt_q    <= div_cnt_d;
            half_q       <= half_d;
            slot_cnt_q   <= slot_cnt_d;
            cmd_sh_q     <= cmd_sh_d;
            addr_sh_q    <= addr_sh_d;
            tx_sh_q      <= tx_sh_d;
            rx_q         <= rx_d;
            addr_en_q    <= addr_en_d;
            fourbyte_q   <= fourbyte_d;
            dir_q        <= dir_d;
            cpol_q       <= cpol_d;
            dummy_q      <= dummy_d;
            nbits_q      <= nbits_d;
            data_slots_q <= data_slots_d;
            cmd_lg_q     <= cmd_lg_d;
            addr_lg_q    <= addr_lg_d;
            data_lg_q    <= data_lg_d;
            data_out_q   <= data_out_d;
        end
    end

    always_comb begin
        in_slot  = (state_q == S_CMD) || (state_q == S_ADDR) ||
                   (state_q == S_DUMMY) || (state_q == S_DATA);
        ready    = (state_q == S_IDLE);
        ss       = (state_q == S_IDLE) || (state_q == S_GAP);
        done     = (state_q == S_GAP) && (div_cnt_q == '0);
        sclk     = in_slot ? half_q : cpol_q;
        data_out = data_out_q;
        {dq_oe, dq_out} = 8'h00;
        case (state_q)
            S_CMD:   {dq_oe, dq_out} = drive_lanes(cmd_sh_q[7:4], cmd_lg_q);
            S_ADDR:  {dq_oe, dq_out} = drive_lanes(addr_sh_q[31:28], addr_lg_q);
            S_DUMMY: {dq_oe, dq_out} = (data_lg_q == 2'd2) ? 8'h00 : 8'hCC;
            S_DATA: begin
                if (dir_q)
                    {dq_oe, dq_out} = drive_lanes(tx_sh_q[DATA_W-1 -: 4], data_lg_q);
                else
                    {dq_oe, dq_out} = (data_lg_q == 2'd2) ? 8'h00 : 8'hCC;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_spi_master_fl_mq.sv
// tb/tb_spi_master_fl_mq.sv - directed self-checking bench for spi_master_fl_mq
module tb_spi_master_fl_mq;
    localparam int DATA_W  = 32;
    localparam int NBITS_W = 7;
    localparam int DUMMY_W = 4;
    localparam int DIV_W   = 8;
    localparam int MAXC    = 512;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid = 1'b0;
    logic               ready;
    logic [7:0]         command = '0;
    logic [31:0]        address = '0;
    logic               addr_en = 1'b0;
    logic               fourbyte = 1'b0;
    logic [DUMMY_W-1:0] dummy_cycles = '0;
    logic [NBITS_W-1:0] ndata_bits = '0;
    logic               dir = 1'b0;
    logic [DATA_W-1:0]  data_in = '0;
    logic [1:0]         cmd_lanes = '0;
    logic [1:0]         addr_lanes = '0;
    logic [1:0]         data_lanes = '0;
    logic [DIV_W-1:0]   clk_div = '0;
    logic               cpol = 1'b0;
    logic [DATA_W-1:0]  data_out;
    logic               done;
    logic               sclk;
    logic               ss;
    logic [3:0]         dq_out;
    logic [3:0]         dq_oe;
    logic [3:0]         dq_in;

    spi_master_fl_mq #(
        .DATA_W(DATA_W), .NBITS_W(NBITS_W), .DUMMY_W(DUMMY_W), .DIV_W(DIV_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready),
        .command(command), .address(address), .addr_en(addr_en), .fourbyte(fourbyte),
        .dummy_cycles(dummy_cycles), .ndata_bits(ndata_bits), .dir(dir), .data_in(data_in),
        .cmd_lanes(cmd_lanes), .addr_lanes(addr_lanes), .data_lanes(data_lanes),
        .clk_div(clk_div), .cpol(cpol), .data_out(data_out), .done(done),
        .sclk(sclk), .ss(ss), .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flash model: after model_skip sclk rises in a frame, presents the next slot's bits on each rise.
    logic [63:0] model_bits = '0;
    int          model_skip = 0;
    int          model_lg   = 0;
    int          rise_cnt   = 0;

    initial begin
        dq_in = 4'h0;
        forever begin
            @(posedge sclk or negedge ss);
            if (!ss && sclk) begin
                rise_cnt++;
                if (rise_cnt >= model_skip) begin
                    case (model_lg)
                        0: begin dq_in = {2'b00, model_bits[63], 1'b0}; model_bits = model_bits << 1; end
                        1: begin dq_in = {2'b00, model_bits[63:62]}; model_bits = model_bits << 2; end
                        default: begin dq_in = model_bits[63:60]; model_bits = model_bits << 4; end
                    endcase
                end
            end else begin
                rise_cnt = 0;
                dq_in    = 4'h0;
            end
        end
    end

    logic       ss_a    [MAXC];
    logic       sclk_a  [MAXC];
    logic       done_a  [MAXC];
    logic       ready_a [MAXC];
    logic [3:0] oe_a    [MAXC];
    logic [3:0] out_a   [MAXC];

    task automatic start_frame(input logic hold);
        int guard = 0;
        @(negedge clk);
        while (!ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_before_accept", 64'(ready), 64'd1);
        valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) valid = 1'b0;
    endtask

    task automatic capture(input int ncyc, input int hold_accepts);
        int acc = 1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            ss_a[c] = ss; sclk_a[c] = sclk; done_a[c] = done;
            ready_a[c] = ready; oe_a[c] = dq_oe; out_a[c] = dq_out;
            if (valid && ready) begin
                acc++;
                if (acc >= hold_accepts) begin
                    @(posedge clk);
                    #1 valid = 1'b0;
                end
            end
        end
    endtask

    function automatic int first_done(input int from, input int upto);
        for (int c = from; c <= upto; c++)
            if (done_a[c]) return c;
        return 0;
    endfunction

    function automatic int ss_cnt(input int from, input int upto, input logic lvl);
        int n = 0;
        for (int c = from; c <= upto; c++)
            if (ss_a[c] == lvl) n++;
        return n;
    endfunction

    function automatic logic [63:0] collect(input int first_slot, input int nslots, input int period, input int lg);
        logic [63:0] v;
        logic [3:0]  o;
        v = '0;
        for (int j = first_slot; j < first_slot + nslots; j++) begin
            o = out_a[period * j + 1];
            case (lg)
                0: v = {v[62:0], o[0]};
                1: v = {v[61:0], o[1:0]};
                default: v = {v[59:0], o};
            endcase
        end
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int d2;
        int done_seen;

        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ready", 64'(ready), 64'd1);
        check_eq("rst_ss", 64'(ss), 64'd1);
        check_eq("rst_sclk", 64'(sclk), 64'd0);
        check_eq("rst_oe", 64'(dq_oe), 64'd0);
        check_eq("rst_dq", 64'(dq_out), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_data_out", 64'(data_out), 64'd0);
        rst_n = 1'b1;

        // Read-ID, single lane, clk_div 0
        command = 8'h9F; addr_en = 1'b0; dummy_cycles = '0; ndata_bits = 7'd24; dir = 1'b0;
        cmd_lanes = 2'd0; addr_lanes = 2'd0; data_lanes = 2'd0; clk_div = 8'd0;
        model_bits = {24'h20BA19, 40'h0}; model_skip = 8; model_lg = 0;
        start_frame(1'b0);
        capture(70, 0);
        d = first_done(1, 70);
        check_eq("rdid_done_cycle", 64'(d), 64'd66);
        check_eq("rdid_ss_low", 64'(ss_cnt(1, 65, 1'b0)), 64'd65);
        check_eq("rdid_ready_gap", 64'(ready_a[66]), 64'd0);
        check_eq("rdid_ready_after", 64'(ready_a[67]), 64'd1);
        check_eq("rdid_data", 64'(data_out), 64'h0020BA19);
        check_eq("rdid_cmd_bits", collect(0, 8, 2, 0), 64'h9F);
        check_eq("rdid_cmd_oe", 64'(oe_a[1]), 64'hD);
        check_eq("rdid_rd_oe", 64'(oe_a[17]), 64'hC);
        check_eq("rdid_sclk_lo", 64'(sclk_a[1]), 64'd0);
        check_eq("rdid_sclk_hi", 64'(sclk_a[2]), 64'd1);

        // Quad fast read
        command = 8'hEB; address = 32'h00123456; addr_en = 1'b1; fourbyte = 1'b0;
        dummy_cycles = 4'd6; ndata_bits = 7'd32; dir = 1'b0;
        cmd_lanes = 2'd0; addr_lanes = 2'd2; data_lanes = 2'd2; clk_div = 8'd0;
        model_bits = {32'hCAFEF00D, 32'h0}; model_skip = 20; model_lg = 2;
        start_frame(1'b0);
        capture(62, 0);
        d = first_done(1, 62);
        check_eq("quad_done_cycle", 64'(d), 64'd58);
        check_eq("quad_ss_low", 64'(ss_cnt(1, 57, 1'b0)), 64'd57);
        check_eq("quad_data", 64'(data_out), 64'hCAFEF00D);
        check_eq("quad_addr_oe", 64'(oe_a[17]), 64'hF);
        check_eq("quad_dummy_oe", 64'(oe_a[29]), 64'h0);
        check_eq("quad_data_oe", 64'(oe_a[41]), 64'h0);
        check_eq("quad_addr_bits", collect(8, 6, 2, 2), 64'h123456);

        // Write, mode 3, clk_div 3, dual data lanes
        cpol = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("m3_idle_sclk", 64'(sclk), 64'd1);
        command = 8'h02; address = 32'h01000000; addr_en = 1'b1; fourbyte = 1'b1;
        dummy_cycles = '0; ndata_bits = 7'd16; dir = 1'b1; data_in = 32'hFFFFA55A;
        cmd_lanes = 2'd0; addr_lanes = 2'd0; data_lanes = 2'd1; clk_div = 8'd3;
        start_frame(1'b0);
        capture(395, 0);
        d = first_done(1, 395);
        check_eq("wr_done_cycle", 64'(d), 64'd389);
        check_eq("wr_ss_low", 64'(ss_cnt(1, 388, 1'b0)), 64'd388);
        check_eq("wr_cmd_bits", collect(0, 8, 8, 0), 64'h02);
        check_eq("wr_addr_bits", collect(8, 32, 8, 0), 64'h01000000);
        check_eq("wr_data_bits", collect(40, 8, 8, 1), 64'hA55A);
        check_eq("wr_sclk_half0", 64'(sclk_a[324]), 64'd0);
        check_eq("wr_sclk_half1", 64'(sclk_a[325]), 64'd1);
        check_eq("wr_data_oe", 64'(oe_a[321]), 64'hF);
        check_eq("wr_end_sclk", 64'(sclk_a[385]), 64'd1);
        check_eq("wr_data_out_kept", 64'(data_out), 64'hCAFEF00D);
        cpol = 1'b0;

        // Odd length: 5 bits over 4 lanes, clk_div 1
        command = 8'h0B; addr_en = 1'b0; dummy_cycles = '0; ndata_bits = 7'd5; dir = 1'b0;
        cmd_lanes = 2'd0; data_lanes = 2'd2; clk_div = 8'd1;
        model_bits = {8'hB6, 56'h0}; model_skip = 8; model_lg = 2;
        start_frame(1'b0);
        capture(48, 0);
        d = first_done(1, 48);
        check_eq("odd_done_cycle", 64'(d), 64'd43);
        check_eq("odd_ss_low", 64'(ss_cnt(1, 42, 1'b0)), 64'd42);
        check_eq("odd_data", 64'(data_out), 64'h16);

        // Oversized length clamps to DATA_W
        ndata_bits = 7'd100; clk_div = 8'd0;
        model_bits = {32'h12345678, 32'h0}; model_skip = 8; model_lg = 2;
        start_frame(1'b0);
        capture(40, 0);
        check_eq("clamp_done_cycle", 64'(first_done(1, 40)), 64'd34);
        check_eq("clamp_data", 64'(data_out), 64'h12345678);

        // Reset in the middle of the address phase
        command = 8'h03; address = 32'h00ABCDEF; addr_en = 1'b1; fourbyte = 1'b0;
        ndata_bits = 7'd8; dir = 1'b0; addr_lanes = 2'd0; data_lanes = 2'd0; clk_div = 8'd0;
        start_frame(1'b0);
        repeat (20) @(negedge clk);
        check_eq("rst_mid_ss_before", 64'(ss), 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ss", 64'(ss), 64'd1);
        check_eq("rst_mid_oe", 64'(dq_oe), 64'd0);
        check_eq("rst_mid_ready", 64'(ready), 64'd1);
        check_eq("rst_mid_data_out", 64'(data_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check_eq("rst_mid_no_done", 64'(done_seen), 64'd0);

        // Normal frame after reset
        command = 8'h9F; addr_en = 1'b0; ndata_bits = 7'd24; dir = 1'b0;
        cmd_lanes = 2'd0; data_lanes = 2'd0; clk_div = 8'd0;
        model_bits = {24'h20BA19, 40'h0}; model_skip = 8; model_lg = 0;
        start_frame(1'b0);
        capture(70, 0);
        check_eq("post_rst_done_cycle", 64'(first_done(1, 70)), 64'd66);
        check_eq("post_rst_data", 64'(data_out), 64'h0020BA19);

        // Back-to-back command-only frames, valid held
        command = 8'h06; addr_en = 1'b0; dummy_cycles = '0; ndata_bits = '0; dir = 1'b1;
        cmd_lanes = 2'd0; clk_div = 8'd1;
        start_frame(1'b1);
        capture(80, 2);
        d = first_done(1, 80);
        check_eq("b2b_done1", 64'(d), 64'd35);
        check_eq("b2b_ready_gap", 64'(ready_a[36]), 64'd0);
        check_eq("b2b_ready_accept", 64'(ready_a[37]), 64'd1);
        check_eq("b2b_gap_ss_high", 64'(ss_cnt(35, 36, 1'b1)), 64'd2);
        check_eq("b2b_ss_low2", 64'(ss_a[38]), 64'd0);
        d2 = first_done(38, 80);
        check_eq("b2b_done2", 64'(d2), 64'd72);
        check_eq("b2b_ss_low_len", 64'(ss_cnt(38, 71, 1'b0)), 64'd34);
        check_eq("b2b_data_out_kept", 64'(data_out), 64'h0020BA19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
